// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, ALU selects, FSM states and control bundle for the sequencer
package cpu_pkg;

    typedef enum logic [4:0] {
        OP_NOP  = 5'b00000,
        OP_ADD  = 5'b00001,
        OP_SUB  = 5'b00010,
        OP_AND  = 5'b00011,
        OP_OR   = 5'b00100,
        OP_XOR  = 5'b00101,
        OP_MOV  = 5'b00110,
        OP_LD   = 5'b00111,
        OP_ST   = 5'b01000,
        OP_MOVI = 5'b10110,
        OP_ADDI = 5'b10111,
        OP_BZ   = 5'b11000,
        OP_BP   = 5'b11001,
        OP_JMP  = 5'b11010,
        OP_HALT = 5'b11111
    } opcode_t;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_PASSA = 4'b1010;
    localparam logic [3:0] ALU_PASSB = 4'b1011;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } state_t;

    typedef enum logic [1:0] {
        BR_NONE,
        BR_ZERO,
        BR_POS,
        BR_JUMP
    } branch_t;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 11;
    localparam int RD_MSB  = 10;
    localparam int RD_LSB  = 8;
    localparam int RS_MSB  = 7;
    localparam int RS_LSB  = 5;
    localparam int RT_MSB  = 4;
    localparam int RT_LSB  = 2;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef struct packed {
        logic [3:0]  alu_sel;
        logic        imm_sel;
        logic [15:0] imm_data;
        logic        mem_sel;
        logic        writes_rd;
        logic        is_store;
        branch_t     branch;
        logic        illegal;
        logic [2:0]  rs_addr;
        logic [2:0]  rt_addr;
        logic [2:0]  rd_addr;
    } ctrl_t;

    function automatic logic op_is_legal(input logic [4:0] op);
        case (op)
            OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV, OP_LD, OP_ST,
            OP_MOVI, OP_ADDI, OP_BZ, OP_BP, OP_JMP, OP_HALT: return 1'b1;
            default:                                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - ROM, flag and datapath control signals between sequencer and datapath
interface control_unit_if #(
    parameter int PC_WIDTH = 8
);
    logic [PC_WIDTH-1:0] instr_addr;
    logic [15:0]         instr_data;
    logic                zero_flag;
    logic                pos_flag;
    logic                rf_write;
    logic [2:0]          rs_addr;
    logic [2:0]          rt_addr;
    logic [2:0]          rd_addr;
    logic [15:0]         imm_data;
    logic                imm_sel;
    logic [3:0]          alu_sel;
    logic                mem_write;
    logic                mem_sel;
    logic                halted;
    logic                illegal_op;

    modport master (
        output instr_addr, rf_write, rs_addr, rt_addr, rd_addr, imm_data, imm_sel,
               alu_sel, mem_write, mem_sel, halted, illegal_op,
        input  instr_data, zero_flag, pos_flag
    );

    modport slave (
        input  instr_addr, rf_write, rs_addr, rt_addr, rd_addr, imm_data, imm_sel,
               alu_sel, mem_write, mem_sel, halted, illegal_op,
        output instr_data, zero_flag, pos_flag
    );
endinterface

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - purely combinational instruction register to control bundle decode
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [15:0] ir,
    output ctrl_t       ctrl
);
    opcode_t op;

    always_comb begin
        op            = opcode_t'(ir[OP_MSB:OP_LSB]);
        ctrl          = '0;
        ctrl.branch   = BR_NONE;
        ctrl.rs_addr  = ir[RS_MSB:RS_LSB];
        ctrl.rt_addr  = ir[RT_MSB:RT_LSB];
        ctrl.rd_addr  = ir[RD_MSB:RD_LSB];
        ctrl.illegal  = !op_is_legal(ir[OP_MSB:OP_LSB]);
        case (op)
            OP_ADD:  begin ctrl.alu_sel = ALU_ADD;   ctrl.writes_rd = 1'b1; end
            OP_SUB:  begin ctrl.alu_sel = ALU_SUB;   ctrl.writes_rd = 1'b1; end
            OP_AND:  begin ctrl.alu_sel = ALU_AND;   ctrl.writes_rd = 1'b1; end
            OP_OR:   begin ctrl.alu_sel = ALU_OR;    ctrl.writes_rd = 1'b1; end
            OP_XOR:  begin ctrl.alu_sel = ALU_XOR;   ctrl.writes_rd = 1'b1; end
            OP_MOV:  begin ctrl.alu_sel = ALU_PASSA; ctrl.writes_rd = 1'b1; end
            OP_LD: begin
                ctrl.alu_sel   = ALU_PASSA;
                ctrl.mem_sel   = 1'b1;
                ctrl.writes_rd = 1'b1;
            end
            OP_ST: begin
                ctrl.alu_sel  = ALU_PASSA;
                ctrl.is_store = 1'b1;
            end
            OP_MOVI: begin
                ctrl.alu_sel   = ALU_PASSB;
                ctrl.imm_sel   = 1'b1;
                ctrl.imm_data  = {8'h00, ir[IMM_MSB:IMM_LSB]};
                ctrl.writes_rd = 1'b1;
            end
            // ADDI reads and writes the same register, so operand A comes from the rd field
            OP_ADDI: begin
                ctrl.alu_sel   = ALU_ADD;
                ctrl.imm_sel   = 1'b1;
                ctrl.imm_data  = {{8{ir[IMM_MSB]}}, ir[IMM_MSB:IMM_LSB]};
                ctrl.rs_addr   = ir[RD_MSB:RD_LSB];
                ctrl.writes_rd = 1'b1;
            end
            OP_BZ: begin
                ctrl.alu_sel = ALU_PASSA;
                ctrl.rs_addr = ir[RD_MSB:RD_LSB];
                ctrl.branch  = BR_ZERO;
            end
            OP_BP: begin
                ctrl.alu_sel = ALU_PASSA;
                ctrl.rs_addr = ir[RD_MSB:RD_LSB];
                ctrl.branch  = BR_POS;
            end
            OP_JMP:  ctrl.branch = BR_JUMP;
            default: ;
        endcase
    end
endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - four-phase fetch/decode/execute/write-back sequencer driving the datapath
module control_unit
    import cpu_pkg::*;
#(
    parameter int                  PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    control_unit_if.master    bus
);
    state_t              state;
    state_t              next_state;
    logic [PC_WIDTH-1:0] pc;
    logic [15:0]         ir;
    logic                illegal_q;
    ctrl_t               ctrl;
    logic [4:0]          fetched_op;
    logic [PC_WIDTH-1:0] br_off;
    logic [PC_WIDTH-1:0] jmp_tgt;
    logic                take_branch;

    instr_decoder u_decoder (
        .ir   (ir),
        .ctrl (ctrl)
    );

    assign fetched_op  = bus.instr_data[OP_MSB:OP_LSB];
    assign br_off      = PC_WIDTH'($signed(ir[IMM_MSB:IMM_LSB]));
    assign jmp_tgt     = PC_WIDTH'(ir[IMM_MSB:IMM_LSB]);
    assign take_branch = (ctrl.branch == BR_ZERO && bus.zero_flag) ||
                         (ctrl.branch == BR_POS  && bus.pos_flag);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_FETCH;
            pc        <= RESET_PC;
            ir        <= '0;
            illegal_q <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                S_DECODE: begin
                    ir <= bus.instr_data;
                    pc <= pc + PC_WIDTH'(1);
                    if (!op_is_legal(fetched_op))
                        illegal_q <= 1'b1;
                end
                // pc already points past this instruction, so offsets are relative to address+1
                S_EXECUTE: begin
                    if (ctrl.branch == BR_JUMP)
                        pc <= jmp_tgt;
                    else if (take_branch)
                        pc <= pc + br_off;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:     next_state = S_DECODE;
            S_DECODE:    next_state = (fetched_op == OP_HALT || !op_is_legal(fetched_op)) ?
                                      S_HALT : S_EXECUTE;
            S_EXECUTE:   next_state = S_WRITEBACK;
            S_WRITEBACK: next_state = S_FETCH;
            S_HALT:      next_state = S_HALT;
            default:     next_state = S_FETCH;
        endcase
    end

    always_comb begin
        bus.instr_addr = pc;
        bus.halted     = (state == S_HALT);
        bus.illegal_op = illegal_q;
        bus.rs_addr    = '0;
        bus.rt_addr    = '0;
        bus.rd_addr    = '0;
        bus.imm_data   = '0;
        bus.imm_sel    = 1'b0;
        bus.alu_sel    = '0;
        bus.mem_sel    = 1'b0;
        bus.mem_write  = 1'b0;
        bus.rf_write   = 1'b0;
        if (state == S_EXECUTE || state == S_WRITEBACK) begin
            bus.rs_addr   = ctrl.rs_addr;
            bus.rt_addr   = ctrl.rt_addr;
            bus.rd_addr   = ctrl.rd_addr;
            bus.imm_data  = ctrl.imm_data;
            bus.imm_sel   = ctrl.imm_sel;
            bus.alu_sel   = ctrl.alu_sel;
            bus.mem_sel   = ctrl.mem_sel;
            bus.mem_write = (state == S_EXECUTE)   && ctrl.is_store  && !ctrl.illegal;
            bus.rf_write  = (state == S_WRITEBACK) && ctrl.writes_rd && !ctrl.illegal;
        end
    end
endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed self-checking bench for the control_unit sequencer
module tb_control_unit;
    import cpu_pkg::*;

    logic        clock;
    logic        reset;
    logic [15:0] rom [0:255];
    int          compared;
    int          mismatched;

    control_unit_if #(.PC_WIDTH(8)) bus ();

    control_unit #(.PC_WIDTH(8), .RESET_PC(8'd0)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) bus.instr_data <= rom[bus.instr_addr];

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        compared      = 0;
        mismatched    = 0;
        reset         = 1'b1;
        bus.zero_flag = 1'b0;
        bus.pos_flag  = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        rom[0] = 16'hB708;
        rom[1] = 16'h0000;
        rom[2] = 16'hD005;
        rom[4] = 16'h4070;
        rom[5] = 16'hC2FE;
        rom[6] = 16'hF800;

        repeat (3) tick();
        check("rst_state",    32'(dut.state), 32'(S_FETCH));
        check("rst_addr",     32'(bus.instr_addr), 32'd0);
        check("rst_enables",  {bus.rf_write, bus.mem_write, bus.halted, bus.illegal_op}, 4'b0000);
        check("rst_ctrl",     {bus.alu_sel, bus.imm_data, bus.imm_sel, bus.rd_addr}, 24'h0);
        reset = 1'b0;

        check("movi_fetch_addr", 32'(bus.instr_addr), 32'd0);
        tick(); tick();
        check("movi_ex_alu",  32'(bus.alu_sel), 32'hB);
        check("movi_ex_imm",  {bus.imm_sel, bus.imm_data}, {1'b1, 16'd8});
        check("movi_ex_rd",   32'(bus.rd_addr), 32'd7);
        check("movi_ex_en",   {bus.rf_write, bus.mem_write}, 2'b00);
        tick();
        check("movi_wb_rf",   32'(bus.rf_write), 32'd1);
        check("movi_wb_rd",   32'(bus.rd_addr), 32'd7);
        tick();
        check("movi_next_addr", 32'(bus.instr_addr), 32'd1);
        check("movi_rf_once", {bus.rf_write, bus.imm_data}, 17'h0);

        tick(); tick(); tick();
        check("nop_wb_rf",    {bus.rf_write, bus.mem_write, bus.alu_sel}, 6'h0);
        tick();
        check("jmp_src_addr", 32'(bus.instr_addr), 32'd2);
        repeat (4) tick();
        check("jmp_dst_addr", 32'(bus.instr_addr), 32'd5);

        bus.zero_flag = 1'b1;
        tick(); tick();
        check("bz_ex_rs",     32'(bus.rs_addr), 32'd2);
        check("bz_ex_ctrl",   {bus.alu_sel, bus.imm_sel, bus.imm_data, bus.rf_write}, {4'hA, 1'b0, 16'h0, 1'b0});
        tick();
        check("bz_wb_rf",     32'(bus.rf_write), 32'd0);
        tick();
        check("bz_taken_addr", 32'(bus.instr_addr), 32'd4);
        bus.zero_flag = 1'b0;

        tick(); tick();
        check("st_ex_mw",     32'(bus.mem_write), 32'd1);
        check("st_ex_regs",   {bus.rs_addr, bus.rt_addr}, {3'd3, 3'd4});
        check("st_ex_rf",     32'(bus.rf_write), 32'd0);
        tick();
        check("st_wb_en",     {bus.mem_write, bus.rf_write}, 2'b00);
        check("st_wb_hold",   {bus.rs_addr, bus.rt_addr}, {3'd3, 3'd4});
        tick();
        check("st_next_addr", 32'(bus.instr_addr), 32'd5);

        bus.pos_flag = 1'b1;
        repeat (3) tick();
        check("bz_nt_wb_rf",  32'(bus.rf_write), 32'd0);
        tick();
        check("bz_nt_addr",   32'(bus.instr_addr), 32'd6);
        bus.pos_flag = 1'b0;

        tick();
        check("halt_dec_halted", 32'(bus.halted), 32'd0);
        tick();
        check("halt_after_dec", {bus.halted, bus.illegal_op}, 2'b10);
        for (int i = 0; i < 22; i++) begin
            tick();
            check("halt_hold", {bus.halted, bus.rf_write, bus.mem_write}, 3'b100);
        end

        rom[0] = 16'hB9FF;
        rom[1] = 16'h0B28;
        rom[2] = 16'h7800;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("halt_rst_addr",   32'(bus.instr_addr), 32'd0);
        check("halt_rst_halted", 32'(bus.halted), 32'd0);

        tick(); tick();
        check("addi_ex_imm",  {bus.imm_sel, bus.imm_data}, {1'b1, 16'hFFFF});
        check("addi_ex_regs", {bus.rs_addr, bus.rd_addr, bus.alu_sel}, {3'd1, 3'd1, 4'h0});
        tick();
        check("addi_wb_rf",   32'(bus.rf_write), 32'd1);
        tick();
        check("add_fetch",    32'(bus.instr_addr), 32'd1);
        tick(); tick();
        check("add_ex_regs",  {bus.rs_addr, bus.rt_addr, bus.rd_addr, bus.imm_sel}, {3'd1, 3'd2, 3'd3, 1'b0});
        reset = 1'b1;
        tick();
        check("add_rst_state", 32'(dut.state), 32'(S_FETCH));
        check("add_rst_addr",  32'(bus.instr_addr), 32'd0);
        check("add_rst_rf",    32'(bus.rf_write), 32'd0);
        reset = 1'b0;
        tick();
        check("add_rst_dec_rf", 32'(bus.rf_write), 32'd0);

        repeat (3) tick();
        repeat (3) tick();
        check("add_wb_rf",    32'(bus.rf_write), 32'd1);
        tick();
        check("ill_fetch",    32'(bus.instr_addr), 32'd2);
        tick();
        check("ill_dec",      {bus.halted, bus.illegal_op}, 2'b00);
        tick();
        check("ill_flags",    {bus.halted, bus.illegal_op}, 2'b11);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("ill_hold", {bus.halted, bus.illegal_op, bus.rf_write, bus.mem_write}, 4'b1100);
        end

        rom[0]   = 16'h3DC0;
        rom[1]   = 16'hD0FF;
        rom[255] = 16'h0000;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("ill_rst_clear", {bus.halted, bus.illegal_op, bus.instr_addr}, 10'h0);
        tick(); tick();
        check("ld_ex_ctrl",   {bus.mem_sel, bus.alu_sel, bus.rs_addr, bus.rd_addr}, {1'b1, 4'hA, 3'd6, 3'd5});
        tick();
        check("ld_wb",        {bus.rf_write, bus.mem_sel}, 2'b11);
        tick();
        check("ld_next_addr", 32'(bus.instr_addr), 32'd1);
        repeat (4) tick();
        check("jmp255_addr",  32'(bus.instr_addr), 32'd255);
        repeat (4) tick();
        check("pc_wrap_addr", 32'(bus.instr_addr), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multi-cycle fetch/decode/execute/write-back sequencer directly upstream of the datapath.
- Fetches 16-bit instructions from a synchronous instruction ROM, decodes them, and drives every datapath control input (register addresses, immediate, ALU select, write enables, muxes).
- Uses the datapath zero/positive flags to resolve conditional branches.
- Fixed 4 cycles per instruction. HALT and illegal opcodes park the core until reset.

Parameters:
- PC_WIDTH, 8, program counter and instr_addr width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clock, in, 1, single system clock; all state updates on rising edge.
- reset, in, 1, synchronous, active-high.
- instr_addr, out, PC_WIDTH, ROM address (the PC). ROM returns data one cycle later.
- instr_data, in, 16, ROM read data.
- zero_flag, in, 1, datapath ALU result == 0.
- pos_flag, in, 1, datapath ALU result > 0 (signed).
- rf_write, out, 1, register file write enable.
- rs_addr, out, 3, ALU operand A register.
- rt_addr, out, 3, ALU operand B / store-data register.
- rd_addr, out, 3, destination register.
- imm_data, out, 16, immediate to datapath.
- imm_sel, out, 1, 1 = ALU B from imm_data.
- alu_sel, out, 4, ALU operation.
- mem_write, out, 1, data memory write enable.
- mem_sel, out, 1, 1 = RF write data from memory, 0 = from ALU.
- halted, out, 1, core stopped by HALT or illegal opcode.
- illegal_op, out, 1, sticky; set when an undefined opcode is decoded.

Behaviour:
- Reset (synchronous, active-high, any state, including mid-instruction):
  - state=FETCH, pc=RESET_PC, ir=0.
  - All control outputs 0; halted=0; illegal_op=0.
- Instruction formats (opcode = ir[15:11]):
  - R: rd=[10:8], rs=[7:5], rt=[4:2].
  - I: rd=[10:8], imm8=[7:0].
  - B: reg=[10:8], off8=[7:0], signed.
- FSM, advancing unconditionally each cycle: FETCH -> DECODE -> EXECUTE -> WRITEBACK -> FETCH.
  - FETCH: instr_addr=pc.
  - DECODE: ir<=instr_data; pc<=pc+1, wrapping mod 2^PC_WIDTH.
  - EXECUTE:
    - rs/rt/rd/imm/imm_sel/alu_sel/mem_sel driven from ir.
    - mem_write=1 for ST only, this cycle only.
    - Branch decision made on flags sampled at end of EXECUTE.
  - WRITEBACK: same operand outputs held; rf_write=1 for one cycle if the opcode writes rd.
  - HALT: terminal; exit only by reset. halted=1; all enables 0.
- Control outputs are functions of state and ir only; no combinational path from flags or instr_data to any output.
- Outside EXECUTE/WRITEBACK, all control outputs are 0.
- Opcodes (alu_sel in brackets):
  - 00000 NOP: no writes.
  - 00001 ADD [0000], 00010 SUB [0001], 00011 AND [0010], 00100 OR [0011], 00101 XOR [0100]: rd=rs op rt.
  - 00110 MOV [1010 passA]: rd=rs.
  - 00111 LD [1010]: rd=mem[rs]; mem_sel=1.
  - 01000 ST [1010]: mem[rs]=rt; mem_write=1 in EXECUTE; no rf_write.
  - 10110 MOVI [1011 passB]: rd=zext(imm8); imm_sel=1.
  - 10111 ADDI [0000]: rd=rd+sext(imm8); rs_addr=rd; imm_sel=1.
  - 11000 BZ / 11001 BP [1010]: rs_addr=reg; if zero_flag / pos_flag then pc<=pc+sext(off8) at end of EXECUTE. pc is already incremented, so target = address+1+off. Wraps mod 2^PC_WIDTH.
  - 11010 JMP: pc<=zext(off8) truncated/extended to PC_WIDTH.
  - 11111 HALT: next state HALT after DECODE.
  - Any other opcode: illegal_op<=1 and next state HALT after DECODE.
- imm_data: zero-extended for MOVI, sign-extended for ADDI, 0 otherwise.

Decomposition:
- Shared package cpu_pkg:
  - opcode_t enum (5-bit).
  - alu_sel constants ALU_ADD … ALU_PASSB (4-bit).
  - state_t enum.
  - Field-slice constants.
- One combinational sub-module, instr_decoder: ir -> control bundle (alu_sel, imm_sel, imm_data, mem_sel, writes_rd, is_store, branch type, illegal). The FSM/PC stays in control_unit.

Test Plan:
- MOVI R7,#8 (16'hB708) at addr 0, then a ROM model:
  - EXECUTE (cycle 3 after reset release): alu_sel=1011, imm_sel=1, imm_data=16'd8, rd_addr=7.
  - WRITEBACK: rf_write=1 for exactly one cycle.
  - Next FETCH: instr_addr=1.
- BZ R2,-2 (16'hC2FE) at addr 5:
  - zero_flag=1 -> next instr_addr=4.
  - zero_flag=0 -> next instr_addr=6.
  - rf_write stays 0 throughout.
- ST (16'h4000 | rs=3 | rt=4): mem_write=1 only in EXECUTE, rs_addr=3, rt_addr=4; rf_write=0.
- HALT (16'hF800): halted=1 from the cycle after DECODE; all enables 0 for 20+ cycles; reset resumes at instr_addr=RESET_PC.
- Illegal opcode 01111: illegal_op=1 and halted=1, never rf_write.
- Assert reset in EXECUTE of an ADD: next cycle state=FETCH, instr_addr=0, rf_write never pulses for that ADD.
- PC wrap: JMP to 255 followed by NOP -> next fetch address 0.
